leaf_out_arbiter: RTL

Single-clock output scheduler for a leaf interface: arbitrates up to NUM_OUT_PORTS user output streams onto the one packet link toward the BFT. It shares the link round-robin, gates each port on a per-destination credit (freespace) counter, stamps each packet with destination leaf, port and a per-port sequence address, and holds the packet until the network accepts it. It sits between the user-kernel vld/ack output ports and the leaf's BFT-facing packet output, in the fast network clock domain.

---
 rtl/leaf_out_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/leaf_out_arbiter.sv
// Leaf output scheduler: round-robin arbitration of user output ports onto the
// single BFT-facing packet link, with per-destination credit gating and sequence stamping.
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 6,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    credit_ret,
    input  logic [NUM_PORT_BITS-1:0]                credit_port,
    output logic [PACKET_BITS-1:0]                  pkt_out,
    input  logic                                    pkt_ready
);

    localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;

    // Credit arithmetic is done one bit wider so return + grant can overshoot before saturation.
    localparam logic [CREDIT_BITS:0]     CREDIT_MAX  = (CREDIT_BITS+1)'(2**NUM_ADDR_BITS);
    localparam logic [CREDIT_BITS:0]     CREDIT_UPD  = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CREDIT_BITS:0]     CREDIT_ONE  = (CREDIT_BITS+1)'(1);
    localparam logic [CREDIT_BITS-1:0]   CREDIT_FULL = CREDIT_BITS'(2**NUM_ADDR_BITS);
    localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE     = NUM_ADDR_BITS'(1);
    localparam logic [NUM_PORT_BITS-1:0] LAST_PORT   = NUM_PORT_BITS'(NUM_OUT_PORTS-1);

    logic [NUM_OUT_PORTS-1:0] enable;
    logic [DEST_BITS-1:0]     dest   [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq    [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] last_grant;
    logic [PACKET_BITS-1:0]   pkt_q;

    logic                     load_slot;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic                     grant_vld;
    logic [NUM_PORT_BITS-1:0] grant_idx;
    logic [PACKET_BITS-1:0]   grant_pkt;
    logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];

    assign pkt_out = pkt_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        eligible  = '0;
        load_slot = !pkt_q[PACKET_BITS-1] || pkt_ready;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user2interface[i] && enable[i] && (credit[i] != '0);
        end
    end

    // Rotating priority: first ports above last_grant, then wrap to the lower ones.
    always_comb begin
        grant_vld          = 1'b0;
        grant_idx          = '0;
        grant_pkt          = '0;
        ack_interface2user = '0;
        if (!reset && load_slot) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (!grant_vld && eligible[i] && (i > int'(last_grant))) begin
                    grant_vld = 1'b1;
                    grant_idx = NUM_PORT_BITS'(i);
                end
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (!grant_vld && eligible[i] && (i <= int'(last_grant))) begin
                    grant_vld = 1'b1;
                    grant_idx = NUM_PORT_BITS'(i);
                end
            end
        end
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant_vld && (grant_idx == NUM_PORT_BITS'(i))) begin
                ack_interface2user[i] = 1'b1;
                grant_pkt = {1'b1, dest[i], seq[i],
                             din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    always_comb begin
        logic [CREDIT_BITS:0] sum;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = {1'b0, credit[i]};
            if (credit_ret && (credit_port == NUM_PORT_BITS'(i)))
                sum = sum + CREDIT_UPD;
            if (grant_vld && (grant_idx == NUM_PORT_BITS'(i)))
                sum = sum - CREDIT_ONE;
            credit_nxt[i] = (sum > CREDIT_MAX) ? CREDIT_FULL : sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pkt_q      <= '0;
            last_grant <= LAST_PORT;
            // NOTE: the per-port tables are small register arrays, not RAM, so they are reset explicitly.
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                enable[i] <= 1'b0;
                dest[i]   <= '0;
                credit[i] <= CREDIT_FULL;
                seq[i]    <= '0;
            end
        end else begin
            if (grant_vld) begin
                pkt_q      <= grant_pkt;
                last_grant <= grant_idx;
            end else if (pkt_ready) begin
                pkt_q[PACKET_BITS-1] <= 1'b0;
            end
            // A config write wins over the seq increment; the grant already used the old values.
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i))) begin
                    enable[i] <= 1'b1;
                    dest[i]   <= cfg_dest;
                    seq[i]    <= '0;
                end else if (grant_vld && (grant_idx == NUM_PORT_BITS'(i))) begin
                    seq[i] <= seq[i] + SEQ_ONE;
                end
            end
        end
    end

endmodule
